// File: rtl/md_pos_pkg.sv
// md_pos_pkg: shared FSM state encoding and FIFO depth for the position cell reader
package md_pos_pkg;
  localparam int FIFO_DEPTH = 4;
  typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, DONE} state_t;
endpackage

// File: rtl/pos_cell_reader_if.sv
// pos_cell_reader_if: valid/ready particle stream from the cell reader to its consumer
interface pos_cell_reader_if #(parameter int DATA_WIDTH = 96, parameter int ADDR_WIDTH = 8);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_pos;
  logic [ADDR_WIDTH-1:0] out_pid;
  logic                  out_last;
  modport master (output out_valid, out_pos, out_pid, out_last, input out_ready);
  modport slave  (input out_valid, out_pos, out_pid, out_last, output out_ready);
endinterface

// File: rtl/pos_reader_fifo.sv
// pos_reader_fifo: FIFO_DEPTH-entry synchronous FIFO with full/empty flags and occupancy
module pos_reader_fifo import md_pos_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic                        clock,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            din,
  output logic [WIDTH-1:0]            dout,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic wr, rd;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign full = count == (PW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign dout = mem[rp];
  // storage is cleared so the head word reads as zero after reset
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (rd) rp <= rp + 1'b1;
      count <= count + (PW+1)'(wr) - (PW+1)'(rd);
    end
endmodule

// File: rtl/pos_cell_reader.sv
// pos_cell_reader: reads a cell's particle count then streams its positions through a credit-limited FIFO
// Optional count clamping with cnt_err flag: define POS_READER_CNT_CLAMP_EN.
module pos_cell_reader import md_pos_pkg::*; #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  pos_cell_reader_if.master     stream,
  output logic [ADDR_WIDTH-1:0] particle_cnt
`ifdef POS_READER_CNT_CLAMP_EN
  ,
  output logic                  cnt_err
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  state_t state, nxt;
  logic [ADDR_WIDTH-1:0] next_addr, pid1, pid2, cnt_lat;
  logic [PW:0] fcnt;
  logic c1, c2, v1, v2, issue, pop, full, empty, cnt_ok;
  assign cnt_ok = state == WAIT_CNT && c2;
  assign pop = stream.out_valid && stream.out_ready;
  // in-flight reads count against FIFO space so returning data always has a slot
  assign issue = state == STREAM && (fcnt + (PW+1)'(v1) + (PW+1)'(v2)) < (PW+1)'(FIFO_DEPTH);
`ifdef POS_READER_CNT_CLAMP_EN
  logic over;
  assign over = mem_q[ADDR_WIDTH-1:0] > ADDR_WIDTH'(PARTICLE_NUM-1);
  assign cnt_lat = over ? ADDR_WIDTH'(PARTICLE_NUM-1) : mem_q[ADDR_WIDTH-1:0];
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) cnt_err <= 1'b0;
    else if (state == IDLE && start) cnt_err <= 1'b0;
    else if (cnt_ok && over) cnt_err <= 1'b1;
`else
  assign cnt_lat = mem_q[ADDR_WIDTH-1:0];
`endif
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = start ? RD_CNT : IDLE;
      RD_CNT:   nxt = WAIT_CNT;
      WAIT_CNT: nxt = !c2 ? WAIT_CNT : cnt_lat == '0 ? DONE : STREAM;
      STREAM:   nxt = issue && next_addr == particle_cnt ? DRAIN : STREAM;
      DRAIN:    nxt = pop && stream.out_last ? DONE : DRAIN;
      default:  nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    mem_rden = state == RD_CNT || issue;
    mem_address = issue ? next_addr : '0;
    mem_wren = 1'b0;
  end
  // two-stage tags mirror the memory read latency; reset drops anything in flight
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      c1 <= 1'b0;
      c2 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      pid1 <= '0;
      pid2 <= '0;
      next_addr <= '0;
      particle_cnt <= '0;
    end else begin
      c1 <= state == RD_CNT;
      c2 <= c1;
      v1 <= issue;
      v2 <= v1;
      pid1 <= next_addr;
      pid2 <= pid1;
      next_addr <= state != STREAM ? ADDR_WIDTH'(1) : next_addr + ADDR_WIDTH'(issue);
      if (cnt_ok) particle_cnt <= cnt_lat;
    end
  pos_reader_fifo #(.WIDTH(DATA_WIDTH + ADDR_WIDTH)) u_fifo (
    .clock(clock),
    .rst_n(rst_n),
    .push(v2),
    .pop(pop),
    .din({pid2, mem_q}),
    .dout({stream.out_pid, stream.out_pos}),
    .full(full),
    .empty(empty),
    .count(fcnt)
  );
  assign stream.out_valid = !empty;
  assign stream.out_last = !empty && stream.out_pid == particle_cnt;
endmodule

// File: tb/tb_pos_cell_reader.sv
// tb_pos_cell_reader: directed scenario tests for pos_cell_reader against a 2-cycle latency memory model
module tb_pos_cell_reader;
  logic clock = 0, rst_n = 0, start = 0;
  logic busy, done, mem_rden, mem_wren;
  logic [7:0] mem_address, particle_cnt;
  logic [95:0] mem_q, q1;
  logic [95:0] mem_arr [256];
  int tests = 0, fails = 0;
  int issued, popped, max_out;
  logic wren_seen;
`ifdef POS_READER_CNT_CLAMP_EN
  logic cnt_err;
`endif
  pos_cell_reader_if bus ();
  pos_cell_reader dut (
    .clock(clock), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_q(mem_q),
    .stream(bus.master), .particle_cnt(particle_cnt)
`ifdef POS_READER_CNT_CLAMP_EN
    , .cnt_err(cnt_err)
`endif
  );
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (mem_rden) q1 <= mem_arr[mem_address];
    mem_q <= q1;
  end
  always @(negedge clock)
    if (!rst_n) begin
      issued = 0;
      popped = 0;
      max_out = 0;
      wren_seen = 0;
    end else begin
      if (mem_rden && mem_address != 0) issued++;
      if (bus.out_valid && bus.out_ready) popped++;
      if (issued - popped > max_out) max_out = issued - popped;
      if (mem_wren) wren_seen = 1;
    end

  function automatic logic [95:0] pos_of(input int i);
    return {32'(i * 5 + 3), 32'hBEEF0000 | 32'(i), 32'(i)};
  endfunction

  task automatic run_cell(input int n_exp, input int mode, input bit repulse,
                          output int beats, output int bad, output int dones,
                          output int lat, output int span, output int hold_bad);
    int first_k, idle;
    logic stall;
    logic [7:0] hp;
    logic [95:0] hpos;
    beats = 0; bad = 0; dones = 0; lat = -1; span = 0; hold_bad = 0;
    first_k = 0; idle = 0; stall = 0; hp = '0; hpos = '0;
    bus.out_ready = 1'b1;
    start = 1;
    @(posedge clock); #1;
    start = 0;
    for (int k = 1; k <= 3000 && idle < 12; k++) begin
      @(posedge clock); #1;
      bus.out_ready = (mode == 0) || (k % 3 == 1);
      start = repulse && (k == 8 || k == 9);
      if (stall && bus.out_valid && (bus.out_pid !== hp || bus.out_pos !== hpos)) hold_bad++;
      if (bus.out_valid && lat < 0) lat = k;
      if (done) dones++;
      if (dones > 0 && !busy) idle++;
      if (bus.out_valid && bus.out_ready) begin
        beats++;
        if (beats == 1) first_k = k;
        span = k - first_k;
        if (bus.out_pid !== 8'(beats) || bus.out_pos !== pos_of(beats) || bus.out_last !== 1'(beats == n_exp)) bad++;
      end
      stall = bus.out_valid && !bus.out_ready;
      hp = bus.out_pid;
      hpos = bus.out_pos;
    end
    start = 0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 0;
    bus.out_ready = 1'b1;
    #23;
    tests++;
    if ({busy, done, mem_rden, mem_wren, bus.out_valid, bus.out_last} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b want 000000", {busy, done, mem_rden, mem_wren, bus.out_valid, bus.out_last});
    end
    tests++;
    if (mem_address !== 8'd0 || particle_cnt !== 8'd0 || bus.out_pid !== 8'd0) begin
      fails++;
      $display("FAIL reset_addr: got addr %0d cnt %0d pid %0d want 0 0 0", mem_address, particle_cnt, bus.out_pid);
    end
    tests++;
    if (bus.out_pos !== 96'd0) begin
      fails++;
      $display("FAIL reset_pos: got %h want 0", bus.out_pos);
    end
    @(negedge clock);
    rst_n = 1;
    @(posedge clock); #1;
  endtask

  task automatic test_count3;
    int beats, bad, dones, lat, span, hold_bad;
    mem_arr[0] = {88'hABCDEF, 8'd3};
    run_cell(3, 0, 0, beats, bad, dones, lat, span, hold_bad);
    tests++;
    if (beats !== 3) begin fails++; $display("FAIL c3_beats: got %0d want 3", beats); end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL c3_content: got %0d bad beats want 0", bad); end
    tests++;
    if (dones !== 1) begin fails++; $display("FAIL c3_done: got %0d pulses want 1", dones); end
    tests++;
    if (lat !== 6) begin fails++; $display("FAIL c3_latency: got %0d want 6", lat); end
    tests++;
    if (span !== 2) begin fails++; $display("FAIL c3_throughput: got span %0d want 2", span); end
    tests++;
    if (particle_cnt !== 8'd3) begin fails++; $display("FAIL c3_cnt: got %0d want 3", particle_cnt); end
  endtask

  task automatic test_count0;
    int beats, bad, dones, lat, span, hold_bad;
    mem_arr[0] = 96'd0;
    run_cell(0, 0, 0, beats, bad, dones, lat, span, hold_bad);
    tests++;
    if (beats !== 0) begin fails++; $display("FAIL c0_beats: got %0d want 0", beats); end
    tests++;
    if (dones !== 1) begin fails++; $display("FAIL c0_done: got %0d pulses want 1", dones); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL c0_busy: got %b want 0", busy); end
  endtask

  task automatic test_backpressure;
    int beats, bad, dones, lat, span, hold_bad;
    mem_arr[0] = 96'd10;
    run_cell(10, 1, 0, beats, bad, dones, lat, span, hold_bad);
    tests++;
    if (beats !== 10) begin fails++; $display("FAIL bp_beats: got %0d want 10", beats); end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL bp_content: got %0d bad beats want 0", bad); end
    tests++;
    if (hold_bad !== 0) begin fails++; $display("FAIL bp_hold: got %0d unstable stalls want 0", hold_bad); end
    tests++;
    if (max_out > 4) begin fails++; $display("FAIL bp_outstanding: got %0d want <=4", max_out); end
    tests++;
    if (dones !== 1) begin fails++; $display("FAIL bp_done: got %0d pulses want 1", dones); end
  endtask

  task automatic test_restart_ignored;
    int beats, bad, dones, lat, span, hold_bad;
    mem_arr[0] = 96'd5;
    run_cell(5, 0, 1, beats, bad, dones, lat, span, hold_bad);
    tests++;
    if (dones !== 1) begin fails++; $display("FAIL rs_done: got %0d pulses want 1", dones); end
    tests++;
    if (beats !== 5 || bad !== 0) begin fails++; $display("FAIL rs_beats: got %0d beats %0d bad want 5 0", beats, bad); end
    tests++;
    if (wren_seen !== 1'b0) begin fails++; $display("FAIL wren: got %b want 0", wren_seen); end
  endtask

  task automatic test_reset_mid;
    int beats, bad, dones, lat, span, hold_bad, got, stray;
    mem_arr[0] = 96'd10;
    got = 0;
    start = 1;
    @(posedge clock); #1;
    start = 0;
    for (int k = 0; k < 50 && got < 2; k++) begin
      if (bus.out_valid && bus.out_ready) got++;
      @(posedge clock); #1;
    end
    tests++;
    if (got !== 2) begin fails++; $display("FAIL rm_prefix: got %0d beats want 2", got); end
    #2 rst_n = 0;
    #1;
    tests++;
    if ({busy, done, mem_rden, bus.out_valid, bus.out_last} !== 5'b0 || mem_address !== 8'd0 ||
        bus.out_pid !== 8'd0 || bus.out_pos !== 96'd0 || particle_cnt !== 8'd0) begin
      fails++;
      $display("FAIL rm_async: got flags %b addr %0d pid %0d cnt %0d want all 0",
               {busy, done, mem_rden, bus.out_valid, bus.out_last}, mem_address, bus.out_pid, particle_cnt);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst_n = 1;
    stray = 0;
    repeat (6) begin
      @(posedge clock); #1;
      if (bus.out_valid || busy) stray++;
    end
    tests++;
    if (stray !== 0) begin fails++; $display("FAIL rm_discard: got %0d stray cycles want 0", stray); end
    run_cell(10, 0, 0, beats, bad, dones, lat, span, hold_bad);
    tests++;
    if (beats !== 10 || bad !== 0 || dones !== 1) begin
      fails++;
      $display("FAIL rm_restream: got %0d beats %0d bad %0d done want 10 0 1", beats, bad, dones);
    end
  endtask

`ifdef POS_READER_CNT_CLAMP_EN
  task automatic test_clamp;
    int beats, bad, dones, lat, span, hold_bad;
    mem_arr[0] = 96'd250;
    run_cell(219, 0, 0, beats, bad, dones, lat, span, hold_bad);
    tests++;
    if (beats !== 219 || bad !== 0) begin fails++; $display("FAIL cl_beats: got %0d beats %0d bad want 219 0", beats, bad); end
    tests++;
    if (cnt_err !== 1'b1 || particle_cnt !== 8'd219) begin
      fails++;
      $display("FAIL cl_err: got err %b cnt %0d want 1 219", cnt_err, particle_cnt);
    end
    mem_arr[0] = 96'd3;
    run_cell(3, 0, 0, beats, bad, dones, lat, span, hold_bad);
    tests++;
    if (cnt_err !== 1'b0 || beats !== 3) begin fails++; $display("FAIL cl_clear: got err %b beats %0d want 0 3", cnt_err, beats); end
  endtask
`endif

  initial begin
    for (int i = 1; i < 256; i++) mem_arr[i] = pos_of(i);
    mem_arr[0] = 96'd0;
    test_reset;
    test_count3;
    test_count0;
    test_backpressure;
    test_restart_ignored;
    test_reset_mid;
`ifdef POS_READER_CNT_CLAMP_EN
    test_clamp;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
